// File: rtl/cic_rate_pkg.sv
// Shared types and constants for the CIC decimation-rate sequencer.
// Holds the FSM state type and the rate table for both CIC stages.
package cic_rate_pkg;

  typedef enum logic [1:0] {
    ST_ZERO,
    ST_LOAD,
    ST_SETTLE,
    ST_RUN
  } state_e;

  localparam int FLUSH_OUTPUTS_DEF  = 12;
  localparam int SETTLE_OUTPUTS_DEF = 16;

  // Rate index: 0=48k, 1=96k, 2=192k, 3=384k.
  function automatic logic [7:0] cic1_dec(input logic [1:0] sel);
    case (sel)
      2'd0:    return 8'd40;
      2'd1:    return 8'd20;
      2'd2:    return 8'd10;
      default: return 8'd20;
    endcase
  endfunction

  function automatic logic [6:0] cic2_dec(input logic [1:0] sel);
    case (sel)
      2'd3:    return 7'd5;
      default: return 7'd20;
    endcase
  endfunction

endpackage

// File: rtl/cic_rate_ctrl_if.sv
// Control and sample-stream bundle between the host/CIC pair and the
// rate sequencer. The sequencer takes the slave side.
interface cic_rate_ctrl_if #(
  parameter int OUT_WIDTH = 24
);
  logic [1:0]           rate_sel;
  logic                 cic2_out_strobe;
  logic [OUT_WIDTH-1:0] cic2_out_data;
  logic [7:0]           cic1_decimation;
  logic [6:0]           cic2_decimation;
  logic                 zero_in;
  logic                 busy;
  logic                 out_valid;
  logic [OUT_WIDTH-1:0] out_data;

  modport slave (
    input  rate_sel, cic2_out_strobe, cic2_out_data,
    output cic1_decimation, cic2_decimation, zero_in, busy, out_valid, out_data
  );

  modport master (
    output rate_sel, cic2_out_strobe, cic2_out_data,
    input  cic1_decimation, cic2_decimation, zero_in, busy, out_valid, out_data
  );
endinterface

// File: rtl/cic_strobe_counter.sv
// Saturating stage-2 strobe counter with synchronous clear and a
// terminal-count hit flag qualified by the incoming strobe.
module cic_strobe_counter #(
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_strobe,
  input  logic [CNT_WIDTH-1:0] i_term,
  output logic [CNT_WIDTH-1:0] o_count,
  output logic                 o_term_hit
);

  logic [CNT_WIDTH-1:0] r_count;

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_strobe && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count    = r_count;
  assign o_term_hit = i_strobe && (r_count == i_term);

endmodule

// File: rtl/cic_rate_ctrl.sv
// Rate-change sequencer for the two-stage receive CIC chain: flush,
// load new decimations, discard the settling transient, then gate samples.
module cic_rate_ctrl
  import cic_rate_pkg::*;
#(
  parameter int OUT_WIDTH      = 24,
  parameter int FLUSH_OUTPUTS  = FLUSH_OUTPUTS_DEF,
  parameter int SETTLE_OUTPUTS = SETTLE_OUTPUTS_DEF,
  parameter int CNT_WIDTH      = 5
) (
  input  logic               clock,
  input  logic               reset,
  cic_rate_ctrl_if.slave     bus
);

  state_e               r_state;
  state_e               w_state_next;
  logic [1:0]           r_applied_sel;
  logic [7:0]           r_cic1_dec;
  logic [6:0]           r_cic2_dec;
  logic                 r_strobe_d;
  logic                 r_run_d;
  logic                 r_out_valid;
  logic [OUT_WIDTH-1:0] r_out_data;

  logic                 w_mismatch;
  logic                 w_cnt_clear;
  logic                 w_term_hit;
  logic [CNT_WIDTH-1:0] w_term;
  logic [CNT_WIDTH-1:0] w_count;

  assign w_mismatch = (bus.rate_sel != r_applied_sel);
  assign w_term     = (r_state == ST_ZERO) ? CNT_WIDTH'(FLUSH_OUTPUTS - 1)
                                           : CNT_WIDTH'(SETTLE_OUTPUTS - 1);

  // The counter is only meaningful in ZERO and SETTLE; every state entry
  // restarts it, so a strobe on a transition edge belongs to the old state.
  assign w_cnt_clear = (w_state_next != r_state) ||
                       (r_state == ST_LOAD) || (r_state == ST_RUN);

  cic_strobe_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (w_cnt_clear),
    .i_strobe   (bus.cic2_out_strobe),
    .i_term     (w_term),
    .o_count    (w_count),
    .o_term_hit (w_term_hit)
  );

  // NOTE: the next-state default is assigned first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_ZERO:   if (w_term_hit) w_state_next = ST_LOAD;
      ST_LOAD:   w_state_next = ST_SETTLE;
      ST_SETTLE: begin
        if (w_mismatch)      w_state_next = ST_ZERO;
        else if (w_term_hit) w_state_next = ST_RUN;
      end
      ST_RUN:    if (w_mismatch) w_state_next = ST_ZERO;
      default:   w_state_next = ST_ZERO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_ZERO;
      r_applied_sel <= 2'd0;
      r_cic1_dec    <= cic1_dec(2'd0);
      r_cic2_dec    <= cic2_dec(2'd0);
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_LOAD) begin
        r_applied_sel <= bus.rate_sel;
        r_cic1_dec    <= cic1_dec(bus.rate_sel);
        r_cic2_dec    <= cic2_dec(bus.rate_sel);
      end
    end
  end

  // A sample passes only if its strobe arrived in RUN and RUN still holds
  // when its data is valid; the last settle strobe is thus discarded too.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_strobe_d  <= 1'b0;
      r_run_d     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_strobe_d <= bus.cic2_out_strobe;
      r_run_d    <= (r_state == ST_RUN);
      if (r_strobe_d && r_run_d && (r_state == ST_RUN)) begin
        r_out_valid <= 1'b1;
        r_out_data  <= bus.cic2_out_data;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.cic1_decimation = r_cic1_dec;
  assign bus.cic2_decimation = r_cic2_dec;
  assign bus.zero_in         = (r_state == ST_ZERO) || (r_state == ST_LOAD);
  assign bus.busy            = (r_state != ST_RUN);
  assign bus.out_valid       = r_out_valid;
  assign bus.out_data        = r_out_data;

endmodule
